// File: rtl/card_game_pkg.sv
// Shared types and constants for the 4x4 card-matching game: FSM state encoding,
// board geometry and a helper that extracts a face id from the packed layout.
package card_game_pkg;

  localparam int unsigned NUM_CARDS = 16;
  localparam int unsigned FACE_W    = 3;
  localparam int unsigned NUM_PAIRS = 8;
  localparam int unsigned LAYOUT_W  = NUM_CARDS * FACE_W;

  typedef enum logic [2:0] {
    IDLE,
    PICK1,
    PICK2,
    SHOW,
    CHECK,
    DONE
  } state_t;

  // Position p occupies layout[3p+2:3p].
  function automatic logic [FACE_W-1:0] face_of(input logic [LAYOUT_W-1:0] lay,
                                                 input logic [3:0]          pos);
    return lay[int'(pos) * FACE_W +: FACE_W];
  endfunction

endpackage

// File: rtl/memory_game_ctrl_reveal_timer.sv
// Reveal timer: load-to-zero / enable counter with a terminal-count flag at
// REVEAL_CYCLES-1. Counting stops at terminal count.
module reveal_timer #(
  parameter int unsigned REVEAL_CYCLES = 25_000_000,
  parameter int unsigned TIMER_W       = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TIMER_W'(REVEAL_CYCLES - 1));

endmodule

// File: rtl/memory_game_ctrl.sv
// Card-matching game sequencer: cursor, face-up/matched tracking, reveal timing,
// match check and scoring. Optional macro CURSOR_2D_EN adds a btn_down row-step input.
module memory_game_ctrl
  import card_game_pkg::*;
#(
  parameter int unsigned REVEAL_CYCLES = 25_000_000,
  parameter int unsigned TIMER_W       = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 btn_move,
  input  logic                 btn_sel,
`ifdef CURSOR_2D_EN
  input  logic                 btn_down,
`endif
  input  logic [LAYOUT_W-1:0]  layout,
  output logic [3:0]           cursor,
  output logic [NUM_CARDS-1:0] face_up,
  output logic [NUM_CARDS-1:0] matched,
  output logic [3:0]           score,
  output logic [7:0]           moves,
  output logic                 busy,
  output logic                 game_over
);

  state_t                state, state_n;
  logic [LAYOUT_W-1:0]   layout_q, layout_n;
  logic [3:0]            first, first_n, second, second_n;
  logic [3:0]            cursor_n, score_n;
  logic [NUM_CARDS-1:0]  face_up_n, matched_n;
  logic [7:0]            moves_n;
  logic                  timer_load, timer_en, timer_tc;
  logic                  sel_ok;

  reveal_timer #(
    .REVEAL_CYCLES (REVEAL_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      layout_q  <= '0;
      first     <= '0;
      second    <= '0;
      cursor    <= '0;
      face_up   <= '0;
      matched   <= '0;
      score     <= '0;
      moves     <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      layout_q  <= layout_n;
      first     <= first_n;
      second    <= second_n;
      cursor    <= cursor_n;
      face_up   <= face_up_n;
      matched   <= matched_n;
      score     <= score_n;
      moves     <= moves_n;
      // Status flags are decoded from the next state so they line up with it.
      busy      <= (state_n == SHOW) || (state_n == CHECK);
      game_over <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n    = state;
    layout_n   = layout_q;
    first_n    = first;
    second_n   = second;
    cursor_n   = cursor;
    face_up_n  = face_up;
    matched_n  = matched;
    score_n    = score;
    moves_n    = moves;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    sel_ok     = !face_up[cursor] && !matched[cursor];

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          layout_n  = layout;
          cursor_n  = '0;
          face_up_n = '0;
          matched_n = '0;
          score_n   = '0;
          moves_n   = '0;
          state_n   = PICK1;
        end
      end

      PICK1, PICK2: begin
        // A select pulse always swallows a coincident cursor pulse, even if ignored.
        if (btn_sel) begin
          if (sel_ok) begin
            face_up_n[cursor] = 1'b1;
            if (state == PICK1) begin
              first_n = cursor;
              state_n = PICK2;
            end else begin
              second_n   = cursor;
              timer_load = 1'b1;
              state_n    = SHOW;
              if (moves != 8'hFF) moves_n = moves + 8'd1;
            end
          end
        end
`ifdef CURSOR_2D_EN
        else if (btn_down) begin
          cursor_n = cursor + 4'd4;
        end
`endif
        else if (btn_move) begin
          cursor_n = cursor + 4'd1;
        end
      end

      SHOW: begin
        timer_en = 1'b1;
        if (timer_tc) state_n = CHECK;
      end

      CHECK: begin
        face_up_n[first]  = 1'b0;
        face_up_n[second] = 1'b0;
        if (face_of(layout_q, first) == face_of(layout_q, second)) begin
          matched_n[first]  = 1'b1;
          matched_n[second] = 1'b1;
          score_n           = score + 4'd1;
        end
        state_n = (score_n == 4'(NUM_PAIRS)) ? DONE : PICK1;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Randomised and directed bench for memory_game_ctrl against a rule-level game model.
module tb_memory_game_ctrl;

  localparam int R = 4;

  typedef enum {M_IDLE, M_PICK1, M_PICK2, M_SHOW, M_CHECK, M_DONE} mmode_t;

  logic        clk = 1'b0;
  logic        reset, start, btn_move, btn_sel, btn_down;
  logic [47:0] layout;
  logic [3:0]  cursor, score;
  logic [15:0] face_up, matched;
  logic [7:0]  moves;
  logic        busy, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_game_ctrl #(.REVEAL_CYCLES(R), .TIMER_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .btn_move  (btn_move),
    .btn_sel   (btn_sel),
`ifdef CURSOR_2D_EN
    .btn_down  (btn_down),
`endif
    .layout    (layout),
    .cursor    (cursor),
    .face_up   (face_up),
    .matched   (matched),
    .score     (score),
    .moves     (moves),
    .busy      (busy),
    .game_over (game_over)
  );

`ifdef CURSOR_2D_EN
  localparam bit HAS_DOWN = 1'b1;
`else
  localparam bit HAS_DOWN = 1'b0;
`endif

  // Game model: board as arrays, reveal as a countdown of remaining face-up cycles.
  mmode_t m_mode;
  int     m_cur, m_score, m_moves, m_first, m_second, m_left;
  bit     m_fu[16];
  bit     m_mt[16];
  int     m_face[16];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input bit a[16]);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_clear();
    m_cur = 0; m_score = 0; m_moves = 0;
    for (int i = 0; i < 16; i++) begin
      m_fu[i] = 1'b0;
      m_mt[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
      m_first = 0; m_second = 0; m_left = 0;
      for (int i = 0; i < 16; i++) m_face[i] = 0;
      m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: if (start) begin
        for (int p = 0; p < 16; p++) m_face[p] = int'(layout[3*p +: 3]);
        model_clear();
        m_mode = M_PICK1;
      end
      M_PICK1, M_PICK2: begin
        if (btn_sel) begin
          if (!m_fu[m_cur] && !m_mt[m_cur]) begin
            m_fu[m_cur] = 1'b1;
            if (m_mode == M_PICK1) begin
              m_first = m_cur;
              m_mode  = M_PICK2;
            end else begin
              m_second = m_cur;
              m_moves  = (m_moves < 255) ? m_moves + 1 : 255;
              m_left   = R;
              m_mode   = M_SHOW;
            end
          end
        end else if (HAS_DOWN && btn_down) m_cur = (m_cur + 4) % 16;
        else if (btn_move) m_cur = (m_cur + 1) % 16;
      end
      M_SHOW: begin
        m_left--;
        if (m_left == 0) m_mode = M_CHECK;
      end
      M_CHECK: begin
        m_fu[m_first]  = 1'b0;
        m_fu[m_second] = 1'b0;
        if (m_face[m_first] == m_face[m_second]) begin
          m_mt[m_first]  = 1'b1;
          m_mt[m_second] = 1'b1;
          m_score++;
        end
        m_mode = (m_score == 8) ? M_DONE : M_PICK1;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("cursor",    16'(cursor),    16'(m_cur));
    check("face_up",   face_up,        pack(m_fu));
    check("matched",   matched,        pack(m_mt));
    check("score",     16'(score),     16'(m_score));
    check("moves",     16'(moves),     16'(m_moves));
    check("busy",      16'(busy),      16'(m_mode == M_SHOW || m_mode == M_CHECK));
    check("game_over", 16'(game_over), 16'(m_mode == M_DONE));
  endtask

  task automatic step(input bit rs, input bit st, input bit mv, input bit sl, input bit dn);
    reset = rs; start = st; btn_move = mv; btn_sel = sl; btn_down = dn;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    reset = 1'b0; start = 1'b0; btn_move = 1'b0; btn_sel = 1'b0; btn_down = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic pick(input int pos);
    for (int i = 0; i < 16 && m_cur != pos; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
  endtask

  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 20) begin
      step(0, 0, 0, 0, 0);
      cycles++;
    end
    check("busy_timeout", 16'(busy), 16'd0);
  endtask

  function automatic logic [47:0] pair_layout();
    logic [47:0] v;
    for (int p = 0; p < 16; p++) v[3*p +: 3] = 3'(p / 2);
    return v;
  endfunction

  int          bcnt;
  int          ids[16];
  logic [47:0] lay_tmp;

  initial begin
    reset = 1'b1; start = 1'b0; btn_move = 1'b0; btn_sel = 1'b0; btn_down = 1'b0;
    layout = pair_layout();
    m_mode = M_IDLE;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_cursor", 16'(cursor), 16'd0);
    check("rst_busy",   16'(busy),   16'd0);

    // Cursor walk and wrap
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    check("cursor_3", 16'(cursor), 16'd3);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 0, 0);
    check("cursor_wrap", 16'(cursor), 16'd0);

    // Matching pair at 0/1; reveal + check lasts R+1 busy cycles
    pick(0);
    pick(1);
    check("match_faceup", face_up, 16'h0003);
    wait_not_busy(bcnt);
    check("match_busy_len", 16'(bcnt), 16'(R + 1));
    check("match_matched", matched, 16'h0003);
    check("match_score",   16'(score), 16'd1);
    check("match_moves",   16'(moves), 16'd1);

    // Mismatch 1/2 with ignored inputs along the way
    step(0, 0, 0, 0, 0);
    m_mode = m_mode;
    reset = 1'b1; step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    pick(1);
    step(0, 0, 0, 1, 0);
    check("reselect_ignored", face_up, 16'h0002);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    check("sel_beats_move_cur", 16'(cursor), 16'd2);
    check("sel_beats_move_fu",  face_up, 16'h0006);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    check("busy_cursor_hold", 16'(cursor), 16'd2);
    wait_not_busy(bcnt);
    check("mismatch_fu",    face_up, 16'h0000);
    check("mismatch_mt",    matched, 16'h0000);
    check("mismatch_score", 16'(score), 16'd0);
    check("mismatch_moves", 16'(moves), 16'd1);

    // Full game, then restart
    step(0, 1, 0, 0, 0);
    for (int p = 0; p < 8; p++) begin
      pick(2 * p);
      pick(2 * p + 1);
      wait_not_busy(bcnt);
    end
    check("full_score",   16'(score), 16'd8);
    check("full_matched", matched, 16'hFFFF);
    check("full_over",    16'(game_over), 16'd1);
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    check("restart_matched", matched, 16'h0000);
    check("restart_over",    16'(game_over), 16'd0);
    check("restart_moves",   16'(moves), 16'd0);

    // Reset during SHOW
    pick(4);
    pick(5);
    idle(2);
    step(1, 0, 0, 0, 0);
    check("rst_show_fu",   face_up, 16'h0000);
    check("rst_show_busy", 16'(busy), 16'd0);
    check("rst_show_cur",  16'(cursor), 16'd0);

`ifdef CURSOR_2D_EN
    step(0, 1, 0, 0, 0);
    pick(13);
    step(0, 0, 0, 0, 1);
    check("down_wrap", 16'(cursor), 16'd1);
    step(0, 0, 1, 0, 1);
    check("down_beats_move", 16'(cursor), 16'd5);
`endif

    // Randomised play: shuffled pair layouts and fully random layouts
    for (int g = 0; g < 24; g++) begin
      for (int p = 0; p < 16; p++) ids[p] = p / 2;
      for (int p = 15; p > 0; p--) begin
        int j, t;
        j = $urandom_range(p, 0);
        t = ids[p]; ids[p] = ids[j]; ids[j] = t;
      end
      for (int p = 0; p < 16; p++) lay_tmp[3*p +: 3] = 3'(ids[p]);
      if (g % 3 == 2) lay_tmp = {$urandom(), $urandom()};
      layout = lay_tmp;
      step(0, 1, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
        int r;
        r = $urandom_range(999, 0);
        step(r < 3, $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 45,
             $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 20);
        if ($urandom_range(99, 0) < 5) layout = {$urandom(), $urandom()};
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
